aes_key_schedule_seq: RTL and testbench
=======================================

Name: aes_key_schedule_seq

Overview:
- Sequential, parametrised AES key expander generating every round key of AES-128/192/256 one 32-bit word per clock.
- Round keys are held in an internal register file and read by round index.
- An inverse-order read mode lets the decryptor fetch keys last-first, so it no longer needs an unrolled combinational chain to reach the final round key.
- Sits between key load logic and the encrypt/decrypt round datapaths.

Parameters:
- KEY_BITS, 128, cipher key length; legal values 128/192/256, any other value is an elaboration error.
- NK, KEY_BITS/32, key words (4/6/8); derived, not overridable.
- NR, NK+6, number of rounds (10/12/14); derived.
- NW, 4*(NR+1), total expanded words (44/52/60); derived.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request expansion; accepted only when ready=1.
- key_in  in  KEY_BITS  cipher key; bits [KEY_BITS-1 -: 32] form w[0].
- ready  out  1  idle, able to accept start.
- done  out  1  one-cycle pulse when expansion completes.
- key_valid  out  1  level; the register file holds a complete schedule.
- rd_idx  in  4  round index 0..NR.
- rd_inv  in  1  0: returns round rd_idx; 1: returns round NR-rd_idx.
- rd_key  out  128  selected round key, word w[4r] in bits [127:96].

Behaviour:
Reset:
- Asynchronous on rst_n=0: state=IDLE, ready=1, done=0, key_valid=0, word counter=0, register file cleared to 0.
- rd_key is 0 after reset.
- Reset mid-expansion aborts it; no done pulse follows.

FSM IDLE:
- On start&ready, key_in is captured into w[0..NK-1] in the same edge.
- Counter i=NK, key_valid<=0, ready<=0, go to EXPAND.
- start with ready=0 is ignored and not queued.

FSM EXPAND, one word per cycle:
- w[i] = w[i-NK] ^ t.
- i%NK==0: t = SubWord(RotWord(w[i-1])) ^ {RCON[i/NK],24'h0}.
- NK==8 && i%8==4: t = SubWord(w[i-1]).
- Otherwise t = w[i-1].
- After writing w[NW-1], go to DONE.

FSM DONE:
- One cycle with done=1, key_valid<=1, ready<=1, then return to IDLE.

Latency:
- Start edge to done high is NW-NK+1 cycles: 41 (128), 47 (192), 53 (256).
- A new start is accepted the cycle done is high; that clears key_valid.

Arithmetic:
- RCON is GF(2^8) doubling from 0x01; indexes 1..10 needed, max 7 for 256, 8 for 192.
- The counter is 6 bits and never wraps; it saturates the FSM to DONE.

Read port:
- Combinational from the register file; effective index e = rd_inv ? NR-rd_idx : rd_idx.
- If rd_idx>NR, rd_key=0 (no wrap, no negative index).
- Reads while key_valid=0 return current partial contents; consumers must gate on key_valid.

Decomposition:
- aes_pkg: RCON table, SBOX table, NK/NR/NW derivation functions, legal KEY_BITS check.
- Sub-module aes_sub_word: 32-bit SubWord using four SBOX lookups, combinational.
- One instance only; the shared encryption S-box is not reused.

Test Plan:
- AES-128 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, pulse start:
  - done appears exactly 41 cycles later.
  - rd_idx=1 gives a0fafe17_88542cb1_23a33939_2a6c7605.
  - rd_idx=10 gives d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
  - rd_inv=1, rd_idx=0 gives the round-10 key.
- AES-192 key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b:
  - done after 47 cycles.
  - round 12 = e98ba06f_448c773c_8ecc7204_01002202.
- AES-256 key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4:
  - done after 53 cycles.
  - round 14 = fe4890d1_e6188d0b_046df344_706c631e.
  - rd_idx=15 gives 0.
- Start pulsed again at cycle 5 of expansion:
  - Ignored; ready stays 0.
  - Result still matches the first key.
- rst_n low at cycle 20 of an AES-128 run:
  - Immediate ready=1, key_valid=0, no done.
  - A fresh start completes normally with correct keys.
- Back-to-back starts issued the cycle done is high:
  - Second expansion begins; key_valid drops the next cycle.
  - The second key's schedule is correct.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES key schedule: state encoding, S-box, round constants,
// and key-length derivation helpers (NK/NR/NW).
// Used by aes_key_schedule_seq and aes_sub_word; contains no logic of its own.
package aes_pkg;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_DONE   = 2'd2
    } ks_state_e;

    function automatic bit key_bits_ok(input int kb);
        return (kb == 128) || (kb == 192) || (kb == 256);
    endfunction

    function automatic int nk_of(input int kb);
        return kb / 32;
    endfunction

    function automatic int nr_of(input int kb);
        return (kb / 32) + 6;
    endfunction

    function automatic int nw_of(input int kb);
        return 4 * (nr_of(kb) + 1);
    endfunction

    // Index 0 is the leftmost byte of the concatenation.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constant for word index i/NK (1..10); 0 outside that range.
    function automatic logic [7:0] rcon(input int idx);
        case (idx)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Purpose: AES SubWord, four independent S-box byte substitutions.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of word_in.
// Ports: word_in (32) in, word_out (32) out.
module aes_sub_word (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);
    import aes_pkg::*;

    assign word_out[31:24] = SBOX[word_in[31:24]];
    assign word_out[23:16] = SBOX[word_in[23:16]];
    assign word_out[15:8]  = SBOX[word_in[15:8]];
    assign word_out[7:0]   = SBOX[word_in[7:0]];

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Purpose: sequential AES-128/192/256 key expander, one 32-bit word per clock, round keys readable by index.
// Latency: start edge to done high is NW-NK+1 cycles (41/47/53); read port is combinational.
// Backpressure: start only accepted while ready=1; a start while busy is dropped, not queued.
// Ports: clk, rst_n (async low); start/key_in load; ready/done/key_valid status;
//        rd_idx/rd_inv select a round (rd_inv reads NR-rd_idx); rd_key returns w[4r..4r+3], w[4r] in [127:96].
module aes_key_schedule_seq #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                ready,
    output logic                done,
    output logic                key_valid,
    input  logic [3:0]          rd_idx,
    input  logic                rd_inv,
    output logic [127:0]        rd_key
);
    import aes_pkg::*;

    if (!key_bits_ok(KEY_BITS)) begin : g_bad_key_bits
        $error("aes_key_schedule_seq: KEY_BITS must be 128, 192 or 256");
    end

    localparam int         NK   = nk_of(KEY_BITS);
    localparam int         NR   = nr_of(KEY_BITS);
    localparam int         NW   = nw_of(KEY_BITS);
    localparam logic [5:0] NK6  = 6'(NK);
    localparam logic [5:0] LAST = 6'(NW - 1);
    localparam logic [3:0] NR4  = 4'(NR);

    ks_state_e   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        key_valid_q, key_valid_d;
    logic [31:0] w_q [NW];
    logic [31:0] w_d [NW];

    logic        accept;
    logic        rot_step;
    logic        sub_step;
    logic [7:0]  rc;
    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp_word;

    assign accept = start && ready_q && (state_q == KS_IDLE);

    // Word-recurrence helpers for w[cnt_q]; only meaningful while expanding.
    assign rot_step  = (int'(cnt_q) % NK) == 0;
    // For NK==8 the extra SubWord falls on i%8==4, i.e. the low three counter bits.
    assign sub_step  = (NK == 8) && (cnt_q[2:0] == 3'd4);
    assign rc        = rcon(int'(cnt_q) / NK);
    assign prev_word = w_q[cnt_q - 6'd1];
    assign back_word = w_q[cnt_q - NK6];
    assign sub_in    = rot_step ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    aes_sub_word u_sub_word (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    assign temp_word = rot_step ? (sub_out ^ {rc, 24'h0}) :
                       sub_step ? sub_out : prev_word;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= KS_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            for (int j = 0; j < NW; j++) begin
                w_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            key_valid_q <= key_valid_d;
            w_q         <= w_d;
        end
    end

    // Next-state logic; the >= compare keeps a corrupted counter from running away.
    always_comb begin
        state_d = state_q;
        case (state_q)
            KS_IDLE:   if (accept) state_d = KS_EXPAND;
            KS_EXPAND: if (cnt_q >= LAST) state_d = KS_DONE;
            KS_DONE:   state_d = KS_IDLE;
            default:   state_d = KS_IDLE;
        endcase
    end

    // Output / datapath logic. Status flags are registered, so done, ready and
    // key_valid rise together on the edge that leaves DONE.
    always_comb begin
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        key_valid_d = key_valid_q;
        w_d         = w_q;
        case (state_q)
            KS_IDLE: begin
                if (accept) begin
                    for (int j = 0; j < NK; j++) begin
                        w_d[6'(j)] = key_in[KEY_BITS-1-32*j -: 32];
                    end
                    cnt_d       = NK6;
                    key_valid_d = 1'b0;
                    ready_d     = 1'b0;
                end
            end
            KS_EXPAND: begin
                w_d[cnt_q] = back_word ^ temp_word;
                if (cnt_q < LAST) cnt_d = cnt_q + 6'd1;
            end
            KS_DONE: begin
                done_d      = 1'b1;
                key_valid_d = 1'b1;
                ready_d     = 1'b1;
            end
            default: ;
        endcase
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign key_valid = key_valid_q;

    // Read port: out-of-range indices return zero rather than wrapping.
    logic [3:0] eff_idx;
    logic [5:0] base;
    always_comb begin
        eff_idx = rd_idx;
        base    = '0;
        rd_key  = '0;
        if (rd_idx <= NR4) begin
            eff_idx = rd_inv ? (NR4 - rd_idx) : rd_idx;
            base    = {eff_idx, 2'b00};
            rd_key  = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
module tb_aes_key_schedule_seq;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst_n;
    logic          start128, start192, start256;
    logic [127:0]  key128;
    logic [191:0]  key192;
    logic [255:0]  key256;
    logic [3:0]    rd_idx;
    logic          rd_inv;
    logic          rdy128, rdy192, rdy256;
    logic          dn128, dn192, dn256;
    logic          kv128, kv192, kv256;
    logic [127:0]  rk128, rk192, rk256;

    aes_key_schedule_seq #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst_n(rst_n), .start(start128), .key_in(key128),
        .ready(rdy128), .done(dn128), .key_valid(kv128),
        .rd_idx(rd_idx), .rd_inv(rd_inv), .rd_key(rk128));
    aes_key_schedule_seq #(.KEY_BITS(192)) dut192 (
        .clk(clk), .rst_n(rst_n), .start(start192), .key_in(key192),
        .ready(rdy192), .done(dn192), .key_valid(kv192),
        .rd_idx(rd_idx), .rd_inv(rd_inv), .rd_key(rk192));
    aes_key_schedule_seq #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst_n(rst_n), .start(start256), .key_in(key256),
        .ready(rdy256), .done(dn256), .key_valid(kv256),
        .rd_idx(rd_idx), .rd_inv(rd_inv), .rd_key(rk256));

    int n_assert = 0;
    int n_fail   = 0;
    int t0       = 0;

    // ---------------- reference model ----------------
    logic [7:0]  sb [256];
    logic [31:0] mw [60];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Key is left-justified in 256 bits.
    task automatic model_expand(input logic [255:0] key, input int nk);
        logic [7:0]  rcv;
        logic [31:0] tmp;
        int          nw;
        nw  = 4 * (nk + 7);
        rcv = 8'h01;
        for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            tmp = mw[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rcv, 24'h0};
                rcv = gmul(rcv, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            mw[i] = mw[i-nk] ^ tmp;
        end
    endtask

    function automatic logic [127:0] model_round(input int r);
        return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

    // ---------------- DUT access helpers ----------------
    function automatic logic ready_of(input int s);
        case (s) 0: return rdy128; 1: return rdy192; default: return rdy256; endcase
    endfunction
    function automatic logic done_of(input int s);
        case (s) 0: return dn128; 1: return dn192; default: return dn256; endcase
    endfunction
    function automatic logic kv_of(input int s);
        case (s) 0: return kv128; 1: return kv192; default: return kv256; endcase
    endfunction
    function automatic logic [127:0] rk_of(input int s);
        case (s) 0: return rk128; 1: return rk192; default: return rk256; endcase
    endfunction

    task automatic set_start(input int s, input logic v);
        case (s)
            0:       start128 = v;
            1:       start192 = v;
            default: start256 = v;
        endcase
    endtask

    task automatic set_key(input logic [255:0] k);
        key128 = k[255:128];
        key192 = k[255:64];
        key256 = k;
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_run(input int s, input logic [255:0] key);
        set_key(key);
        set_start(s, 1'b1);
        @(negedge clk);
        t0 = cyc;
        set_start(s, 1'b0);
    endtask

    task automatic wait_done(input int s, output int lat);
        for (int n = 0; n < 150 && !done_of(s); n++) @(negedge clk);
        lat = cyc - t0;
    endtask

    task automatic read_rk(input int s, input int idx, input logic inv, output logic [127:0] k);
        rd_idx = 4'(idx);
        rd_inv = inv;
        #1;
        k = rk_of(s);
    endtask

    task automatic check_all(input int s, input int nk);
        logic [127:0] k;
        logic [127:0] e;
        int nr;
        nr = nk + 6;
        for (int r = 0; r < 16; r++) begin
            for (int inv = 0; inv < 2; inv++) begin
                read_rk(s, r, inv[0], k);
                e = (r > nr) ? 128'h0 : model_round(inv != 0 ? nr - r : r);
                chk($sformatf("s%0d_round%0d_inv%0d", s, r, inv), k, e);
            end
        end
    endtask

    task automatic full_run(input int s, input logic [255:0] key, input int nk);
        int lat;
        start_run(s, key);
        wait_done(s, lat);
        chk($sformatf("s%0d_latency", s), 128'(lat), 128'(4 * (nk + 7) - nk + 1));
        chk($sformatf("s%0d_kv_at_done", s), 128'(kv_of(s)), 128'd1);
        chk($sformatf("s%0d_ready_at_done", s), 128'(ready_of(s)), 128'd1);
        model_expand(key, nk);
        check_all(s, nk);
        @(negedge clk);
        chk($sformatf("s%0d_done_one_cycle", s), 128'(done_of(s)), 128'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [127:0] k;
        logic [255:0] ka;
        logic [255:0] kb;
        int lat;

        rst_n = 1'b0;
        start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
        set_key('0);
        rd_idx = 4'd0;
        rd_inv = 1'b0;
        build_sbox();
        repeat (2) @(negedge clk);

        // Reset state
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("s%0d_rst_ready", s), 128'(ready_of(s)), 128'd1);
            chk($sformatf("s%0d_rst_done", s), 128'(done_of(s)), 128'd0);
            chk($sformatf("s%0d_rst_kv", s), 128'(kv_of(s)), 128'd0);
            read_rk(s, 0, 1'b0, k);
            chk($sformatf("s%0d_rst_rdkey", s), k, 128'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer vectors
        full_run(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        read_rk(0, 1, 1'b0, k);
        chk("kat128_round1", k, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(0, 10, 1'b0, k);
        chk("kat128_round10", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_rk(0, 0, 1'b1, k);
        chk("kat128_inv0", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        full_run(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 6);
        read_rk(1, 12, 1'b0, k);
        chk("kat192_round12", k, 128'he98ba06f448c773c8ecc720401002202);

        full_run(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 8);
        read_rk(2, 14, 1'b0, k);
        chk("kat256_round14", k, 128'hfe4890d1e6188d0b046df344706c631e);
        read_rk(2, 15, 1'b0, k);
        chk("kat256_idx15", k, 128'h0);
        read_rk(2, 15, 1'b1, k);
        chk("kat256_idx15_inv", k, 128'h0);

        // Start pulsed during expansion is ignored
        ka = rand_key();
        kb = rand_key();
        start_run(0, ka);
        repeat (4) @(negedge clk);
        set_key(kb);
        set_start(0, 1'b1);
        #1;
        chk("busy_ready_low", 128'(ready_of(0)), 128'd0);
        @(negedge clk);
        set_start(0, 1'b0);
        chk("busy_ready_still_low", 128'(ready_of(0)), 128'd0);
        wait_done(0, lat);
        chk("busy_latency", 128'(lat), 128'd41);
        model_expand(ka, 4);
        check_all(0, 4);
        @(negedge clk);

        // Reset in the middle of an expansion
        start_run(0, rand_key());
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 128'(rdy128), 128'd1);
        chk("midrst_kv", 128'(kv128), 128'd0);
        chk("midrst_done", 128'(dn128), 128'd0);
        read_rk(0, 0, 1'b0, k);
        chk("midrst_rdkey", k, 128'h0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_done", 128'(dn128), 128'd0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("postrst_no_done", 128'(dn128), 128'd0);
            chk("postrst_ready", 128'(rdy128), 128'd1);
        end
        full_run(0, rand_key(), 4);

        // Back-to-back: new start accepted in the done cycle
        ka = rand_key();
        kb = rand_key();
        start_run(0, ka);
        wait_done(0, lat);
        chk("b2b_first_latency", 128'(lat), 128'd41);
        chk("b2b_kv_at_done", 128'(kv128), 128'd1);
        start_run(0, kb);
        chk("b2b_kv_dropped", 128'(kv128), 128'd0);
        chk("b2b_ready_low", 128'(rdy128), 128'd0);
        chk("b2b_done_low", 128'(dn128), 128'd0);
        wait_done(0, lat);
        chk("b2b_second_latency", 128'(lat), 128'd41);
        model_expand(kb, 4);
        check_all(0, 4);
        @(negedge clk);

        // Random keys on every key length
        for (int s = 0; s < 3; s++) begin
            for (int n = 0; n < 2; n++) begin
                full_run(s, rand_key(), 4 + 2 * s);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
